store_access_sequencer: RTL
===========================

# store_access_sequencer

Sequences pipeline store operations onto the word-wide data memory, which has no byte enables. Word stores issue directly. Byte and halfword stores run a read-modify-write: read the word, merge the new lanes, write it back. The block sits between the MEM stage and the data cache/memory port, and stalls the pipeline through `busy` until the store is complete.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `store_req`  in  1  MEM-stage store request. Held with its operands stable while `busy`=1.
- `func3`  in  3  store size: 000 = sb, 001 = sh, 010 = sw. Any other value is treated as sw.
- `addr`  in  `ADDR_W`  byte address.
- `data2`  in  32  store data from rs2.
- `busy`  out  1  stall request to the pipeline.
- `store_done`  out  1  one-cycle pulse when the store retires.
- `misalign_fault`  out  1  one-cycle pulse with `store_done` on a trapped misaligned store. Tied to 0 when the feature is compiled out.
- `mem_addr`  out  `ADDR_W`  word-aligned address; bits [1:0] are always 0.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_writedata`  out  32  word to write.
- `mem_readdata`  in  32  word returned by a read.
- `mem_busywait`  in  1  memory busy. A read or write completes in the first cycle its strobe is high and `mem_busywait`=0.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `busy` = `store_req` (combinational).
  - On `store_req`=1, register `func3`, `addr` and `data2`, and drive `mem_addr` = {addr[ADDR_W-1:2], 2'b00}.
  - sw goes to WRITE with `mem_writedata` = `data2`.
  - sb and sh go to READ.
- READ:
  - `mem_read`=1 and `busy`=1.
  - On completion, capture `mem_readdata`, form the merged word and go to WRITE.
- Merge rules:
  - sb replaces byte lane addr[1:0] with data2[7:0].
  - sh replaces the half selected by addr[1] with data2[15:0].
  - All other lanes are kept from the read data.
- WRITE:
  - `mem_write`=1 and `busy`=1.
  - On completion, go to DONE.
- DONE:
  - `busy`=0 and `store_done`=1 for exactly one cycle, then go to IDLE.
  - `store_req` sampled in DONE belongs to the retiring instruction and is ignored.
- Strobe rules:
  - `mem_read` and `mem_write` are never high together.
  - `mem_addr` is stable from accept until DONE.
- Reset, including mid-transaction: state goes to IDLE and every registered output clears. Any outstanding memory access is abandoned.
- Reset values: `busy` 0 (forced low while `reset`=1), `store_done` 0, `misalign_fault` 0, `mem_read` 0, `mem_write` 0, `mem_addr` 0, `mem_writedata` 0.

## Timing
- Memory strobes, address and write data are registered. `busy` is combinational from state and `store_req`.
- sw with `mem_busywait`=0:
  - cycle 0: accept.
  - cycle 1: WRITE.
  - cycle 2: DONE.
  - The pipeline stalls for 2 cycles.
- sb/sh with `mem_busywait`=0:
  - cycle 0: accept.
  - cycle 1: READ.
  - cycle 2: WRITE.
  - cycle 3: DONE.
  - The pipeline stalls for 3 cycles.
- Each `mem_busywait`=1 cycle in READ or WRITE adds one cycle.
- Back-to-back stores: the next store can be accepted in the cycle after DONE.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - A store is misaligned when it is sh with addr[0]=1, or sw with addr[1:0]≠0.
  - A misaligned store goes from IDLE directly to DONE with no memory access, pulsing `misalign_fault` and `store_done` together.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - Offending low bits are ignored: sh uses addr[1] only, and sw writes the aligned word.
  - `misalign_fault` is constant 0.

## Structure
- Package `store_ctrl_pkg`:
  - state enum.
  - func3 constants `F3_SB`, `F3_SH`, `F3_SW`.
- Sub-module `store_lane_merge`: combinational merge of old word, data, func3 and addr[1:0] into the new word. It is reusable by the cache write path.

## Test plan
- sw, addr 0x100, data 0xDEADBEEF, busywait 0 -> one write to 0x100 with 0xDEADBEEF; `store_done` in cycle 2; no read.
- sb, addr 0x103, data 0xAB, read returns 0x11223344 -> write 0xAB223344 to 0x100; `store_done` in cycle 3.
- sh, addr 0x202, data 0xCAFE, read returns 0x11223344, busywait high for 3 cycles in each access -> write 0xCAFE3344; `busy` high for 9 cycles.
- sh at addr 0x101:
  - with `STORE_MISALIGN_TRAP_EN`: no memory strobe; `misalign_fault` and `store_done` pulse in cycle 1.
  - without it: read-modify-write of the lower half.
- `reset` asserted in the first READ cycle -> `mem_read` 0 immediately, FSM in IDLE, no write ever issued.
- Two consecutive sw with `store_req` held through DONE -> exactly two writes, second accepted in the cycle after the first DONE.

Source files
------------

// File: rtl/store_ctrl_pkg.sv
// Shared constants and helpers for the store access sequencer.
// Build option: STORE_MISALIGN_TRAP_EN enables the misaligned-store trap.
package store_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    function automatic logic is_sub_word(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH);
    endfunction

    // Any func3 other than sb/sh behaves as sw, including for alignment.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        if (f3 == F3_SB) return 1'b0;
        if (f3 == F3_SH) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Merges store data into an existing word by func3 and byte offset.
// Reusable by any word-wide write path lacking byte enables.
module store_lane_merge
    import store_ctrl_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  func3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] new_word_o
);

    always_comb begin
        new_word_o = old_word_i;
        if (func3_i == F3_SB) begin
            new_word_o[{off_i, 3'b000} +: 8] = data_i[7:0];
        end else if (func3_i == F3_SH) begin
            new_word_o[{off_i[1], 4'b0000} +: 16] = data_i[15:0];
        end else begin
            new_word_o = data_i;
        end
    end

endmodule

// File: rtl/store_access_sequencer.sv
// Sequences sb/sh/sw onto a word-only memory using read-modify-write.
// Build option: STORE_MISALIGN_TRAP_EN traps misaligned sh/sw.
module store_access_sequencer
    import store_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              store_req,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data2,
    output logic              busy,
    output logic              store_done,
    output logic              misalign_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_busywait
);

    logic [1:0]        state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              mis_c;
    logic [31:0]       merged_c;

`ifdef STORE_MISALIGN_TRAP_EN
    assign mis_c = is_misaligned(func3, addr[1:0]);
`else
    assign mis_c = 1'b0;
`endif

    store_lane_merge u_merge (
        .old_word_i (mem_readdata),
        .data_i     (data_q),
        .func3_i    (func3_q),
        .off_i      (off_q),
        .new_word_o (merged_c)
    );

    always_comb begin
        state_d = state_q;
        func3_d = func3_q;
        off_d   = off_q;
        data_d  = data_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (store_req) begin
                    func3_d = func3;
                    off_d   = addr[1:0];
                    data_d  = data2;
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    if (mis_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else if (is_sub_word(func3)) begin
                        state_d = S_READ;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        wr_d    = 1'b1;
                        wdata_d = data2;
                    end
                end
            end
            S_READ: begin
                if (!mem_busywait) begin
                    state_d = S_WRITE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b1;
                    wdata_d = merged_c;
                end
            end
            S_WRITE: begin
                if (!mem_busywait) begin
                    state_d = S_DONE;
                    wr_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            // store_req seen here belongs to the retiring store
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            func3_q <= 3'b000;
            off_q   <= 2'b00;
            data_q  <= 32'h0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            func3_q <= func3_d;
            off_q   <= off_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign busy = !reset && (((state_q == S_IDLE) && store_req) ||
                             (state_q == S_READ) ||
                             (state_q == S_WRITE));

    assign store_done     = done_q;
    assign misalign_fault = fault_q;
    assign mem_addr       = addr_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;

endmodule
